// File: rtl/sysarr_pkg.sv
// sysarr_pkg: constants and FSM encoding shared by the systolic-array
// source side (skew feeder) and the PE row.
package sysarr_pkg;

    localparam int DATA_BW_DEF   = 8;
    localparam int WEIGHT_BW_DEF = 8;
    localparam int MATRIX_SIZE   = 8;
    localparam int PSUM_BW       = 19;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN
    } feeder_state_e;

endpackage

// File: rtl/sysarr_skew_line.sv
// sysarr_skew_line: DEPTH-stage delay line carrying one lane's data and
// valid bit; the feeder builds its diagonal skew from one per lane.
module sysarr_skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         vin,
    output logic [W-1:0] dout,
    output logic         vout
);

    logic [W-1:0]     d_r [DEPTH];
    logic [DEPTH-1:0] v_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            v_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_r[k] <= '0;
            end
        end else begin
            d_r[0] <= din;
            v_r[0] <= vin;
            for (int k = 1; k < DEPTH; k++) begin
                d_r[k] <= d_r[k-1];
                v_r[k] <= v_r[k-1];
            end
        end
    end

    assign dout = d_r[DEPTH-1];
    assign vout = v_r[DEPTH-1];

endmodule

// File: rtl/sysarr_skew_feeder.sv
// sysarr_skew_feeder: loads PE-row weights and streams diagonally skewed
// input vectors. Optional SYSARR_FEEDER_STATS_EN adds a stall counter.
module sysarr_skew_feeder
    import sysarr_pkg::*;
#(
    parameter int DATA_BW     = DATA_BW_DEF,
    parameter int WEIGHT_BW   = WEIGHT_BW_DEF,
    parameter int MATRIX_SIZE = sysarr_pkg::MATRIX_SIZE,
    parameter int LEN_BW      = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [MATRIX_SIZE*WEIGHT_BW-1:0] w_data,
    input  logic                           start,
    input  logic [LEN_BW-1:0]              vec_len,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [MATRIX_SIZE*DATA_BW-1:0] in_data,
    output logic [MATRIX_SIZE*WEIGHT_BW-1:0] WEIGHTS,
    output logic                           we_rl,
    output logic [MATRIX_SIZE*DATA_BW-1:0] DIN,
    output logic [MATRIX_SIZE-1:0]         DIN_VLD,
    output logic                           busy,
    output logic                           done
`ifdef SYSARR_FEEDER_STATS_EN
    ,
    output logic [15:0]                    stall_cnt
`endif
);

    localparam int DCW = $clog2(MATRIX_SIZE);

    feeder_state_e     state;
    logic              loaded;
    logic [LEN_BW-1:0] len_q;
    logic [LEN_BW-1:0] vec_cnt;
    logic [DCW-1:0]    drain_cnt;
    logic              w_fire;
    logic              fire;
    logic              job_req;
    logic              job_start;
    logic              job_empty;

    assign w_fire    = w_valid && w_ready;
    assign fire      = in_valid && in_ready;
    assign job_req   = (state == S_IDLE) && !w_fire && start && loaded;
    assign job_start = job_req && (vec_len != '0);
    assign job_empty = job_req && (vec_len == '0);

    always_ff @(posedge clk) begin
        if (rstn) begin
            state     <= S_IDLE;
            w_ready   <= 1'b0;
            in_ready  <= 1'b0;
            WEIGHTS   <= '0;
            we_rl     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            loaded    <= 1'b0;
            len_q     <= '0;
            vec_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            we_rl <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    w_ready <= 1'b1;
                    if (w_fire) begin
                        WEIGHTS <= w_data;
                        we_rl   <= 1'b1;
                        w_ready <= 1'b0;
                        state   <= S_LOAD_W;
                    end else if (job_start) begin
                        len_q    <= vec_len;
                        vec_cnt  <= '0;
                        busy     <= 1'b1;
                        w_ready  <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= S_STREAM;
                    end else if (job_empty) begin
                        done <= 1'b1;
                    end
                end
                S_LOAD_W: begin
                    loaded  <= 1'b1;
                    w_ready <= 1'b1;
                    state   <= S_IDLE;
                end
                S_STREAM: begin
                    if (fire) begin
                        vec_cnt <= vec_cnt + 1'b1;
                        if (vec_cnt == len_q - 1'b1) begin
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                            state     <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // done lands when the last lane of the last vector is on DIN
                    if (done) begin
                        w_ready <= 1'b1;
                        state   <= S_IDLE;
                    end else if (drain_cnt == DCW'(MATRIX_SIZE - 2)) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef SYSARR_FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rstn || job_start) begin
            stall_cnt <= '0;
        end else if (state == S_STREAM && !in_valid && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        localparam int LO = (MATRIX_SIZE - 1 - i) * DATA_BW;
        sysarr_skew_line #(
            .DEPTH (i + 1),
            .W     (DATA_BW)
        ) u_line (
            .clk  (clk),
            .rst  (rstn),
            .din  (fire ? in_data[LO +: DATA_BW] : '0),
            .vin  (fire),
            .dout (DIN[LO +: DATA_BW]),
            .vout (DIN_VLD[MATRIX_SIZE-1-i])
        );
    end

endmodule

// File: tb/tb_sysarr_skew_feeder.sv
// tb_sysarr_skew_feeder: table-driven jobs plus hand-written corner
// sequences, with a per-lane scoreboard checked every cycle.
module tb_sysarr_skew_feeder;

    localparam int M  = 8;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic            w_valid;
    logic            w_ready;
    logic [M*WW-1:0] w_data;
    logic            start;
    logic [LW-1:0]   vec_len;
    logic            in_valid;
    logic            in_ready;
    logic [M*DW-1:0] in_data;
    logic [M*WW-1:0] WEIGHTS;
    logic            we_rl;
    logic [M*DW-1:0] DIN;
    logic [M-1:0]    DIN_VLD;
    logic            busy;
    logic            done;
`ifdef SYSARR_FEEDER_STATS_EN
    logic [15:0]     stall_cnt;
`endif

    always #5 clk = ~clk;

    sysarr_skew_feeder #(
        .DATA_BW     (DW),
        .WEIGHT_BW   (WW),
        .MATRIX_SIZE (M),
        .LEN_BW      (LW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .WEIGHTS   (WEIGHTS),
        .we_rl     (we_rl),
        .DIN       (DIN),
        .DIN_VLD   (DIN_VLD),
        .busy      (busy),
        .done      (done)
`ifdef SYSARR_FEEDER_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct {
        int            due;
        int            lane;
        logic [DW-1:0] data;
    } lane_ev_t;

    typedef struct {
        int          len;
        logic [15:0] pat;
        int          npat;
        logic [63:0] vec0;
        int          stall;
    } job_t;

    lane_ev_t        sb[$];
    int              done_q[$];
    int              we_q[$];
    int              cyc = 0;
    int              n_pass = 0;
    int              n_total = 0;
    bit              mon_en = 1'b0;
    logic [M*WW-1:0] cur_w = '0;
    job_t            jobs[4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        logic [M*DW-1:0] ed;
        logic [M-1:0]    ev;
        logic            edone;
        logic            ewe;
        if (mon_en) begin
            ed = '0;
            ev = '0;
            edone = 1'b0;
            ewe = 1'b0;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc) begin
                    ed[(M-1-sb[k].lane)*DW +: DW] = sb[k].data;
                    ev[M-1-sb[k].lane] = 1'b1;
                    sb.delete(k);
                end
            end
            for (int k = done_q.size() - 1; k >= 0; k--) begin
                if (done_q[k] == cyc) begin
                    edone = 1'b1;
                    done_q.delete(k);
                end
            end
            for (int k = we_q.size() - 1; k >= 0; k--) begin
                if (we_q[k] == cyc) begin
                    ewe = 1'b1;
                    we_q.delete(k);
                end
            end
            check("din_vld", DIN_VLD, ev);
            check("din", DIN, ed);
            check("done", done, edone);
            check("we_rl", we_rl, ewe);
        end
    end

    task automatic apply_reset();
        rstn = 1'b1;
        tick();
        sb.delete();
        done_q.delete();
        we_q.delete();
        cur_w = '0;
        mon_en = 1'b1;
        check("rst_w_ready", w_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_weights", WEIGHTS, 0);
        rstn = 1'b0;
        tick();
        check("idle_w_ready", w_ready, 1);
    endtask

    task automatic load_weights(input logic [63:0] w);
        check("w_ready_pre", w_ready, 1);
        w_valid = 1'b1;
        w_data = w;
        tick();
        we_q.push_back(cyc);
        cur_w = w;
        w_valid = 1'b0;
        check("w_ready_loadw", w_ready, 0);
        check("weights_loadw", WEIGHTS, cur_w);
        tick();
        check("weights_after", WEIGHTS, cur_w);
        check("w_ready_after", w_ready, 1);
    endtask

    task automatic run_job(input int len, input logic [15:0] pat,
                           input int npat, input logic [63:0] vec0,
                           input int exp_stall, input bit wv_during);
        int acc = 0;
        int p = 0;
        int t = 0;
        start = 1'b1;
        vec_len = LW'(len);
        tick();
        start = 1'b0;
        check("busy_start", busy, 1);
        if (wv_during) begin
            w_valid = 1'b1;
            w_data = ~cur_w;
        end
        while (acc < len) begin
            check("in_ready_stream", in_ready, 1);
            if (wv_during) check("w_ready_stream", w_ready, 0);
            in_valid = (p >= npat) ? 1'b1 : pat[p];
            in_data = (acc == 0) ? vec0 : {$urandom, $urandom};
            tick();
            p++;
            if (in_valid) begin
                t = cyc;
                for (int i = 0; i < M; i++)
                    sb.push_back('{t + i, i, in_data[(M-1-i)*DW +: DW]});
                acc++;
            end
        end
        in_valid = 1'b0;
        w_valid = 1'b0;
        done_q.push_back(t + M - 1);
        check("in_ready_drain", in_ready, 0);
        while (cyc < t + M - 1) begin
            check("busy_drain", busy, 1);
            tick();
        end
        check("busy_done", busy, 0);
        tick();
        check("w_ready_idle", w_ready, 1);
        check("busy_idle", busy, 0);
        check("weights_hold", WEIGHTS, cur_w);
`ifdef SYSARR_FEEDER_STATS_EN
        check("stall_cnt", stall_cnt, exp_stall);
`endif
    endtask

    initial begin
        jobs[0] = '{1, 16'h0001, 1, 64'h1122334455667788, 0};
        jobs[1] = '{4, 16'h002D, 6, 64'hA1B2C3D4E5F60718, 2};
        jobs[2] = '{3, 16'h001C, 5, 64'h8090A0B0C0D0E0F0, 2};
        jobs[3] = '{2, 16'h0003, 2, 64'hFF00FF00FF00FF00, 0};

        rstn = 1'b1;
        w_valid = 1'b0;
        w_data = '0;
        start = 1'b0;
        vec_len = '0;
        in_valid = 1'b0;
        in_data = '0;
        apply_reset();

        // start without weights, both non-zero and zero length
        start = 1'b1;
        vec_len = 16'd3;
        tick();
        check("nowt_busy", busy, 0);
        check("nowt_in_ready", in_ready, 0);
        vec_len = 16'd0;
        tick();
        start = 1'b0;
        check("nowt0_busy", busy, 0);
        tick();

        load_weights(64'h0102030405060708);

        // zero-length job: done next cycle, busy never high
        start = 1'b1;
        vec_len = 16'd0;
        tick();
        start = 1'b0;
        done_q.push_back(cyc);
        check("zl_busy", busy, 0);
        check("zl_in_ready", in_ready, 0);
        tick();
        check("zl_busy2", busy, 0);

        for (int j = 0; j < 4; j++)
            run_job(jobs[j].len, jobs[j].pat, jobs[j].npat,
                    jobs[j].vec0, jobs[j].stall, 1'b0);

        // weight load beats a same-cycle start
        w_valid = 1'b1;
        w_data = 64'hDEADBEEFCAFEF00D;
        start = 1'b1;
        vec_len = 16'd2;
        tick();
        we_q.push_back(cyc);
        cur_w = 64'hDEADBEEFCAFEF00D;
        w_valid = 1'b0;
        start = 1'b0;
        check("race_in_ready", in_ready, 0);
        check("race_busy", busy, 0);
        tick();
        check("race_weights", WEIGHTS, cur_w);
        check("race_in_ready2", in_ready, 0);
        run_job(2, 16'h0001, 1, 64'h0F1E2D3C4B5A6978, 0, 1'b1);

        // reset mid-stream after 2 of 5 vectors
        start = 1'b1;
        vec_len = 16'd5;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data = {$urandom, $urandom};
            tick();
            for (int i = 0; i < M; i++)
                sb.push_back('{cyc + i, i, in_data[(M-1-i)*DW +: DW]});
        end
        in_valid = 1'b0;
        apply_reset();
        start = 1'b1;
        vec_len = 16'd2;
        tick();
        start = 1'b0;
        check("post_rst_busy", busy, 0);
        check("post_rst_in_ready", in_ready, 0);
        tick();
        load_weights(64'h7766554433221100);
        run_job(1, 16'h0001, 1, 64'h0123456789ABCDEF, 0, 1'b0);

        for (int k = 0; k < 3; k++) tick();
        check("sb_empty", sb.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        check("we_q_empty", we_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
